// File: rtl/seq_arb.sv
// seq_arb: round-robin scheduler in front of a single pattern sequencer.
//
// Each requester presents a table of SEQ_CNT steps {value, dur}. When the
// block is idle, the first requester at or above the round-robin pointer
// wins. Its table is latched and played on SEQ: each step's value is held
// for dur+1 cycles. A single FIN cycle then pulses DONE to the winner.
// ABORT during a run drops straight back to idle without a DONE pulse.
//
// Ports:
//   CLK   - clock
//   RST   - synchronous active-high reset
//   REQ   - level request, one bit per requester
//   PTN   - step tables. Requester r is in slice r (r=0 at the LSBs).
//           Step 0 is the most significant field of a slice.
//           Each step is {value[BW_SEQ], dur[BW_DUR]}.
//   ABORT - terminate the current run (honoured only while running)
//   GNT   - one-hot grant, held for the whole run
//   DONE  - one-cycle completion pulse to the granted requester
//   BUSY  - high while running and during the FIN cycle
//   SEQ   - registered sequence output, RV when not running
module seq_arb #(
  parameter int                NREQ    = 2,
  parameter int                BW_SEQ  = 6,
  parameter int                SEQ_CNT = 6,
  parameter int                BW_DUR  = 3,
  parameter logic [BW_SEQ-1:0] RV      = 6'b000001
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic [NREQ-1:0]                               REQ,
  input  logic [NREQ*SEQ_CNT*(BW_SEQ+BW_DUR)-1:0]       PTN,
  input  logic                                          ABORT,
  output logic [NREQ-1:0]                               GNT,
  output logic [NREQ-1:0]                               DONE,
  output logic                                          BUSY,
  output logic [BW_SEQ-1:0]                             SEQ
);

  localparam int SW = BW_SEQ + BW_DUR;
  localparam int TW = SEQ_CNT * SW;
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(SEQ_CNT);
  localparam logic [CW-1:0] LAST = CW'(SEQ_CNT - 1);
  localparam logic [PW-1:0] PMAX = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [CW-1:0]       step_q, step_d;
  logic [BW_DUR-1:0]   timer_q, timer_d;
  logic [TW-1:0]       tbl_q, tbl_d;
  logic [BW_SEQ-1:0]   seq_q, seq_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                busy_q, busy_d;

  logic                win_any;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       cand;
  logic [TW-1:0]       win_tbl;

  // Step 0 lives in the most significant field of a table.
  function automatic logic [BW_SEQ-1:0] step_val(input logic [TW-1:0] t,
                                                 input logic [CW-1:0] k);
    return t[(SEQ_CNT - 1 - int'(k)) * SW + BW_DUR +: BW_SEQ];
  endfunction

  function automatic logic [BW_DUR-1:0] step_dur(input logic [TW-1:0] t,
                                                 input logic [CW-1:0] k);
    return t[(SEQ_CNT - 1 - int'(k)) * SW +: BW_DUR];
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
    return (g == PMAX) ? '0 : g + PW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] g);
    logic [NREQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!win_any && REQ[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_tbl = PTN[int'(win_idx) * TW +: TW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    step_d  = step_q;
    timer_d = timer_q;
    tbl_d   = tbl_q;
    seq_d   = seq_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = RUN;
          gidx_d  = win_idx;
          tbl_d   = win_tbl;
          step_d  = '0;
          timer_d = '0;
          seq_d   = step_val(win_tbl, '0);
          gnt_d   = onehot(win_idx);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // ABORT outranks the terminal count of the last step.
        if (ABORT) begin
          state_d = IDLE;
          seq_d   = RV;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_after(gidx_q);
        end else if (timer_q == step_dur(tbl_q, step_q)) begin
          if (step_q == LAST) begin
            state_d = FIN;
            done_d  = gnt_q;
            gnt_d   = '0;
            seq_d   = RV;
            ptr_d   = ptr_after(gidx_q);
          end else begin
            step_d  = step_q + CW'(1);
            timer_d = '0;
            seq_d   = step_val(tbl_q, step_q + CW'(1));
          end
        end else begin
          timer_d = timer_q + BW_DUR'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered control and outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      step_q  <= '0;
      timer_q <= '0;
      seq_q   <= RV;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      seq_q   <= seq_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Latched step table (pure data, only meaningful while a run is active)
  always_ff @(posedge CLK) begin
    tbl_q <= tbl_d;
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign BUSY = busy_q;
  assign SEQ  = seq_q;

endmodule

// File: tb/tb_seq_arb.sv
// tb_seq_arb: table-driven and directed bench for seq_arb (default params).
module tb_seq_arb;

  localparam logic [5:0] RV = 6'b000001;

  logic         CLK = 1'b0;
  logic         RST;
  logic         ABORT;
  logic [1:0]   REQ;
  logic [107:0] PTN;
  logic [1:0]   GNT;
  logic [1:0]   DONE;
  logic         BUSY;
  logic [5:0]   SEQ;

  seq_arb #(
    .NREQ(2), .BW_SEQ(6), .SEQ_CNT(6), .BW_DUR(3), .RV(6'b000001)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .PTN(PTN), .ABORT(ABORT),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY), .SEQ(SEQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  req;
    logic [53:0] p0;
    logic [53:0] p1;
    logic [1:0]  gnt;
  } vec_t;

  vec_t        vecs[5];
  int          n_chk = 0;
  int          n_err = 0;
  logic [5:0]  exp_q[$];
  logic [1:0]  cur_gnt;
  logic [53:0] WALK, ALT, ZERO, ALL7;

  // Build a table: vals/durs hold step 0 in their most significant field.
  function automatic logic [53:0] mk_tbl(input logic [35:0] vals, input logic [17:0] durs);
    logic [53:0] t;
    t = '0;
    for (int k = 0; k < 6; k++)
      t[(5-k)*9 +: 9] = {vals[(5-k)*6 +: 6], durs[(5-k)*3 +: 3]};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expand a table into the per-cycle SEQ values it must produce.
  task automatic load_exp(input logic [53:0] t);
    logic [5:0] v;
    logic [2:0] d;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      v = t[(5-k)*9+3 +: 6];
      d = t[(5-k)*9 +: 3];
      for (int c = 0; c <= int'(d); c++) exp_q.push_back(v);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = '0; ABORT = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_seq", SEQ, RV);
    chk("rst_gnt", GNT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_busy", BUSY, 0);
  endtask

  // Called while the DUT is idle; the grant lands on the next edge.
  task automatic start_run(input logic [1:0] req, input logic [1:0] eg,
                           input logic [53:0] tbl, input logic drop);
    load_exp(tbl);
    cur_gnt = eg;
    REQ = req;
    @(negedge CLK);
    chk("grant", GNT, eg);
    chk("busy_start", BUSY, 1);
    chk("done_start", DONE, 0);
    chk("seq", SEQ, exp_q.pop_front());
    if (drop) REQ = '0;
  endtask

  task automatic play(input int n);
    repeat (n) begin
      @(negedge CLK);
      chk("seq", SEQ, exp_q.pop_front());
      chk("gnt_hold", GNT, cur_gnt);
      chk("busy_run", BUSY, 1);
      chk("done_run", DONE, 0);
    end
  endtask

  task automatic finish_run();
    chk("run_len", exp_q.size(), 0);
    @(negedge CLK);
    chk("fin_done", DONE, cur_gnt);
    chk("fin_gnt", GNT, 0);
    chk("fin_seq", SEQ, RV);
    chk("fin_busy", BUSY, 1);
    @(negedge CLK);
    chk("idle_done", DONE, 0);
    chk("idle_gnt", GNT, 0);
    chk("idle_seq", SEQ, RV);
    chk("idle_busy", BUSY, 0);
  endtask

  task automatic after_abort();
    chk("abort_seq", SEQ, RV);
    chk("abort_gnt", GNT, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    @(negedge CLK);
    chk("abort_done2", DONE, 0);
    chk("abort_busy2", BUSY, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    WALK = mk_tbl({6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000},
                  {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
    ALT  = mk_tbl({6'b101010, 6'b010101, 6'b110011, 6'b001100, 6'b111000, 6'b000111},
                  {3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0});
    ZERO = mk_tbl({6'b000011, 6'b000110, 6'b001100, 6'b011000, 6'b110000, 6'b100001},
                  {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0});
    ALL7 = mk_tbl({6{6'b111111}}, {6{3'd7}});

    vecs[0] = '{req: 2'b01, p0: WALK, p1: ALT,  gnt: 2'b01};
    vecs[1] = '{req: 2'b01, p0: ALT,  p1: WALK, gnt: 2'b01};
    vecs[2] = '{req: 2'b11, p0: WALK, p1: ZERO, gnt: 2'b10};
    vecs[3] = '{req: 2'b10, p0: ZERO, p1: ALT,  gnt: 2'b10};
    vecs[4] = '{req: 2'b11, p0: ZERO, p1: WALK, gnt: 2'b01};

    RST = 1'b1; REQ = '0; ABORT = 1'b0; PTN = '0;
    repeat (2) @(negedge CLK);
    do_reset();

    // Table-driven single runs; pointer carries over between records.
    for (int i = 0; i < 5; i++) begin
      PTN = {vecs[i].p1, vecs[i].p0};
      start_run(vecs[i].req, vecs[i].gnt,
                (vecs[i].gnt == 2'b01) ? vecs[i].p0 : vecs[i].p1, 1'b1);
      play(exp_q.size());
      finish_run();
    end

    // Both requesters held: alternating grants, one idle cycle between runs.
    do_reset();
    PTN = {ALT, ZERO};
    start_run(2'b11, 2'b01, ZERO, 1'b0); play(exp_q.size()); finish_run();
    start_run(2'b11, 2'b10, ALT,  1'b0); play(exp_q.size()); finish_run();
    start_run(2'b11, 2'b01, ZERO, 1'b0); play(exp_q.size()); finish_run();
    start_run(2'b11, 2'b10, ALT,  1'b0); play(exp_q.size()); finish_run();
    REQ = '0;

    // Abort during step 2, then requester 1 wins the next contest.
    do_reset();
    PTN = {ALT, WALK};
    start_run(2'b01, 2'b01, WALK, 1'b1);
    play(3);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    after_abort();
    start_run(2'b11, 2'b10, ALT, 1'b1); play(exp_q.size()); finish_run();

    // Table change mid-run does not disturb the active run.
    start_run(2'b01, 2'b01, WALK, 1'b1);
    play(5);
    PTN = {ALT, ALL7};
    play(exp_q.size());
    finish_run();
    start_run(2'b01, 2'b01, ALL7, 1'b1); play(exp_q.size()); finish_run();

    // Reset during step 3 (pointer is 1 beforehand, 0 afterwards).
    PTN = {ALT, WALK};
    start_run(2'b01, 2'b01, WALK, 1'b1);
    play(6);
    chk("step3_seq", SEQ, 6'b001000);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mrst_seq", SEQ, RV);
    chk("mrst_gnt", GNT, 0);
    chk("mrst_done", DONE, 0);
    chk("mrst_busy", BUSY, 0);
    start_run(2'b11, 2'b01, WALK, 1'b1); play(exp_q.size()); finish_run();

    // Abort on the last cycle of step 5 beats the terminal count.
    start_run(2'b01, 2'b01, WALK, 1'b1);
    play(20);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    after_abort();
    start_run(2'b11, 2'b10, ALT, 1'b1); play(exp_q.size()); finish_run();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
